clint_cmd_master: RTL and testbench

Hardware register-bus initiator that drives the CLINT register file on behalf of on-chip agents, such as a boot/power sequencer or an IPI mailbox, without a core having to run software. It accepts one command at a time and expands it into a sequence of 32-bit reg-bus transactions:
- set or clear software interrupts for a hart mask;
- program the 64-bit `mtimecmp` of each hart in a mask, using a glitch-free write order;
- coherently read the 64-bit `mtime`.

It sits on the initiator side of the CLINT's `reg_req_t`/`reg_rsp_t` port, typically behind a reg-bus demux.

---
 rtl/clint_cmd_master.sv | 216 +++++++++++++++++++++
 tb/tb_clint_cmd_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clint_cmd_master.sv
// Reg-bus initiator that expands one CLINT command (msip set/clear, mtimecmp
// programming, coherent mtime read) into a sequence of 32-bit register accesses.
package clint_cmd_master_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module clint_cmd_master #(
    parameter int          NumHarts   = 5,
    parameter logic [31:0] BaseAddr   = 32'h0,
    parameter int          MaxRetries = 3,
    parameter type         reg_req_t  = clint_cmd_master_pkg::reg_req_t,
    parameter type         reg_rsp_t  = clint_cmd_master_pkg::reg_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [NumHarts-1:0] cmd_hart_mask_i,
    input  logic [63:0]         cmd_data_i,
    output reg_req_t            reg_req_o,
    input  reg_rsp_t            reg_rsp_i,
    output logic                done_o,
    output logic                done_err_o,
    output logic [63:0]         done_data_o
);
    localparam int HW = (NumHarts > 1) ? $clog2(NumHarts) : 1;
    localparam int RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    localparam logic [1:0] OP_SET_MSIP = 2'd0;
    localparam logic [1:0] OP_CLR_MSIP = 2'd1;
    localparam logic [1:0] OP_WR_TCMP  = 2'd2;
    localparam logic [1:0] OP_RD_MTIME = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_MSIP, S_TC_LO_MAX, S_TC_HI, S_TC_LO,
        S_RT_HI1, S_RT_LO, S_RT_HI2, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q;
    logic [NumHarts-1:0] mask_q;
    logic [63:0]         data_q;
    logic [31:0]         hi1_q, lo_q;
    logic [RW-1:0]       retry_q;
    logic                done_err_q;
    logic [63:0]         done_data_q;

    logic [HW-1:0]       cur_hart;
    logic [31:0]         hart_ofs;
    logic [NumHarts-1:0] mask_rest;
    logic                last_hart, xfer, rsp_err, hi_match, retries_done;
    logic                res_err;
    logic [63:0]         res_data;

    // The pending mask is consumed lowest bit first, giving ascending hart order.
    always_comb begin
        cur_hart = '0;
        for (int i = NumHarts - 1; i >= 0; i--) begin
            if (mask_q[i]) cur_hart = HW'(i);
        end
    end

    assign hart_ofs     = 32'(cur_hart);
    assign mask_rest    = mask_q & (mask_q - NumHarts'(1));
    assign last_hart    = (mask_rest == '0);
    assign xfer         = reg_req_o.valid && reg_rsp_i.ready;
    assign rsp_err      = xfer && reg_rsp_i.error;
    assign hi_match     = (reg_rsp_i.rdata == hi1_q);
    assign retries_done = (retry_q == RW'(MaxRetries));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        res_err  = 1'b0;
        res_data = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_op_i == OP_RD_MTIME)      state_d = S_RT_HI1;
                    else if (cmd_hart_mask_i == '0)   state_d = S_DONE;
                    else if (cmd_op_i == OP_WR_TCMP)  state_d = S_TC_LO_MAX;
                    else                              state_d = S_MSIP;
                end
            end
            S_MSIP:      if (xfer && last_hart) state_d = S_DONE;
            S_TC_LO_MAX: if (xfer) state_d = S_TC_HI;
            S_TC_HI:     if (xfer) state_d = S_TC_LO;
            S_TC_LO:     if (xfer) state_d = last_hart ? S_DONE : S_TC_LO_MAX;
            S_RT_HI1:    if (xfer) state_d = S_RT_LO;
            S_RT_LO:     if (xfer) state_d = S_RT_HI2;
            S_RT_HI2: begin
                if (xfer) begin
                    if (hi_match) begin
                        state_d  = S_DONE;
                        res_data = {hi1_q, lo_q};
                    end else if (retries_done) begin
                        state_d  = S_DONE;
                        res_err  = 1'b1;
                        res_data = {reg_rsp_i.rdata, lo_q};
                    end else begin
                        state_d  = S_RT_LO;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A bus error abandons whatever accesses remain.
        if (rsp_err) begin
            state_d  = S_DONE;
            res_err  = 1'b1;
            res_data = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q        <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            hi1_q       <= '0;
            lo_q        <= '0;
            retry_q     <= '0;
            done_err_q  <= 1'b0;
            done_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q    <= cmd_op_i;
                        mask_q  <= cmd_hart_mask_i;
                        data_q  <= cmd_data_i;
                        retry_q <= '0;
                    end
                end
                S_MSIP, S_TC_LO: if (xfer) mask_q <= mask_rest;
                S_RT_HI1:        if (xfer) hi1_q <= reg_rsp_i.rdata;
                S_RT_LO:         if (xfer) lo_q <= reg_rsp_i.rdata;
                S_RT_HI2: begin
                    if (xfer && !hi_match && !retries_done) begin
                        hi1_q   <= reg_rsp_i.rdata;
                        retry_q <= retry_q + RW'(1);
                    end
                end
                default: ;
            endcase
            if (state_d == S_DONE && state_q != S_DONE) begin
                done_err_q  <= res_err;
                done_data_q <= res_data;
            end
        end
    end

    // Request fields are a pure function of registered state, so they hold
    // steady for as long as a transfer is stalled.
    always_comb begin
        reg_req_o   = '0;
        cmd_ready_o = (state_q == S_IDLE);
        done_o      = (state_q == S_DONE);
        unique case (state_q)
            S_MSIP: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.wstrb = 4'hF;
                reg_req_o.addr  = BaseAddr + (hart_ofs << 2);
                reg_req_o.wdata = (op_q == OP_SET_MSIP) ? 32'd1 : 32'd0;
            end
            S_TC_LO_MAX, S_TC_LO: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.wstrb = 4'hF;
                reg_req_o.addr  = BaseAddr + 32'h4000 + (hart_ofs << 3);
                reg_req_o.wdata = (state_q == S_TC_LO_MAX) ? 32'hFFFF_FFFF : data_q[31:0];
            end
            S_TC_HI: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.wstrb = 4'hF;
                reg_req_o.addr  = BaseAddr + 32'h4004 + (hart_ofs << 3);
                reg_req_o.wdata = data_q[63:32];
            end
            S_RT_HI1, S_RT_HI2: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.addr  = BaseAddr + 32'hBFFC;
            end
            S_RT_LO: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.addr  = BaseAddr + 32'hBFF8;
            end
            default: ;
        endcase
    end

    assign done_err_o  = done_err_q;
    assign done_data_o = done_data_q;

    logic unused_op;
    assign unused_op = (op_q == OP_CLR_MSIP);
endmodule

// File: tb/tb_clint_cmd_master.sv
// Directed bench for clint_cmd_master: a scripted reg-bus responder, an expected
// access queue built from the CLINT address map, and a table of commands.
module tb_clint_cmd_master;
  import clint_cmd_master_pkg::*;

  localparam int NH = 5;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [NH-1:0] cmd_mask;
  logic [63:0] cmd_data;
  reg_req_t req;
  reg_rsp_t rsp;
  logic done, done_err;
  logic [63:0] done_data;

  always #5 clk = ~clk;

  clint_cmd_master #(.NumHarts(NH), .BaseAddr(BASE), .MaxRetries(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_hart_mask_i(cmd_mask), .cmd_data_i(cmd_data),
    .reg_req_o(req), .reg_rsp_i(rsp),
    .done_o(done), .done_err_o(done_err), .done_data_o(done_data)
  );

  typedef struct {
    logic [1:0]    op;
    logic [NH-1:0] mask;
    logic [63:0]   data;
    int            stall;
    int            errb;
    int            nretry;
    int            lat;
    logic          err;
    logic [63:0]   dat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [68:0] exp_q[$];
  logic [68:0] mon_q[$];
  logic [31:0] rd_q[$];
  int stall_cfg, err_beat, beat_idx, stall_cnt;
  logic [68:0] held;
  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] txn(input logic [31:0] a, input logic w, input logic [31:0] d);
    return {BASE + a, w, d, w ? 4'hF : 4'h0};
  endfunction

  // Responder for the upcoming clock edge; called once per negedge.
  task automatic bus_cycle();
    logic [68:0] cur;
    cur = {req.addr, req.write, req.wdata, req.wstrb};
    rsp = '0;
    if (req.valid) begin
      if (stall_cnt > 0) check("stable_during_stall", cur, held);
      held = cur;
      if (stall_cnt < stall_cfg) begin
        stall_cnt++;
      end else begin
        rsp.ready = 1'b1;
        rsp.error = (beat_idx == err_beat);
        if (!req.write && rd_q.size() > 0) rsp.rdata = rd_q.pop_front();
        mon_q.push_back(cur);
        beat_idx++;
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  endtask

  task automatic build_exp(input vec_t v);
    exp_q.delete();
    case (v.op)
      2'd0, 2'd1: begin
        for (int h = 0; h < NH; h++)
          if (v.mask[h]) exp_q.push_back(txn(32'(4 * h), 1'b1, (v.op == 2'd0) ? 32'd1 : 32'd0));
      end
      2'd2: begin
        for (int h = 0; h < NH; h++) begin
          if (v.mask[h]) begin
            exp_q.push_back(txn(32'h4000 + 32'(8 * h), 1'b1, 32'hFFFF_FFFF));
            exp_q.push_back(txn(32'h4004 + 32'(8 * h), 1'b1, v.data[63:32]));
            exp_q.push_back(txn(32'h4000 + 32'(8 * h), 1'b1, v.data[31:0]));
          end
        end
      end
      default: begin
        exp_q.push_back(txn(32'hBFFC, 1'b0, 32'd0));
        exp_q.push_back(txn(32'hBFF8, 1'b0, 32'd0));
        exp_q.push_back(txn(32'hBFFC, 1'b0, 32'd0));
        for (int r = 0; r < v.nretry; r++) begin
          exp_q.push_back(txn(32'hBFF8, 1'b0, 32'd0));
          exp_q.push_back(txn(32'hBFFC, 1'b0, 32'd0));
        end
      end
    endcase
    if (v.errb >= 0)
      while (exp_q.size() > v.errb + 1) void'(exp_q.pop_back());
  endtask

  // Entered and left on a negedge with the DUT idle.
  task automatic do_vec(input vec_t v, input string tag);
    int lat, busy, n;
    build_exp(v);
    stall_cfg = v.stall; err_beat = v.errb; beat_idx = 0; stall_cnt = 0;
    mon_q.delete();
    cmd_valid = 1'b1; cmd_op = v.op; cmd_mask = v.mask; cmd_data = v.data;
    check($sformatf("%s_accept_ready", tag), cmd_ready, 1);
    bus_cycle();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_mask = NH'($urandom);
    cmd_data = {$urandom, $urandom};
    lat = 0; busy = 0;
    do begin
      @(negedge clk);
      lat++;
      bus_cycle();
      if (!done && cmd_ready) busy++;
    end while (!done && lat < 400);
    check($sformatf("%s_done_latency", tag), lat, v.lat);
    check($sformatf("%s_done_err", tag), done_err, v.err);
    check($sformatf("%s_done_data", tag), done_data, v.dat);
    check($sformatf("%s_ready_low_while_busy", tag), busy, 0);
    check($sformatf("%s_num_accesses", tag), mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_access%0d", tag, i), mon_q[i], exp_q[i]);
    @(negedge clk);
    bus_cycle();
    check($sformatf("%s_done_one_cycle", tag), done, 0);
    check($sformatf("%s_ready_after_done", tag), cmd_ready, 1);
    check($sformatf("%s_result_held", tag), {done_err, done_data}, {v.err, v.dat});
  endtask

  initial begin
    vec_t v;
    int saw_done;
    // op, mask, data, stall, errb, nretry, lat, err, dat
    vecs[0] = '{2'd0, 5'b10101, 64'h0, 0, -1, 0, 4, 1'b0, 64'h0};
    vecs[1] = '{2'd1, 5'b00011, 64'h0, 0, -1, 0, 3, 1'b0, 64'h0};
    vecs[2] = '{2'd2, 5'b00100, 64'h0000_0001_2345_6789, 2, -1, 0, 10, 1'b0, 64'h0};
    vecs[3] = '{2'd2, 5'b10010, 64'hAAAA_BBBB_CCCC_DDDD, 0, -1, 0, 7, 1'b0, 64'h0};
    vecs[4] = '{2'd2, 5'b00000, 64'h1234, 0, -1, 0, 1, 1'b0, 64'h0};
    vecs[5] = '{2'd0, 5'b11111, 64'h0, 1, -1, 0, 11, 1'b0, 64'h0};
    vecs[6] = '{2'd1, 5'b00111, 64'h0, 0, 1, 0, 3, 1'b1, 64'h0};
    vecs[7] = '{2'd0, 5'b00000, 64'h0, 0, -1, 0, 1, 1'b0, 64'h0};
    vecs[8] = '{2'd2, 5'b00011, 64'h5555_6666_7777_8888, 0, 3, 0, 5, 1'b1, 64'h0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_data = '0; rsp = '0;
    stall_cfg = 0; err_beat = -1; beat_idx = 0; stall_cnt = 0; held = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_req_zero", req, '0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_done", done, 0);
    check("reset_done_err", done_err, 0);
    check("reset_done_data", done_data, 0);

    // Coherent mtime read: one retry after the high word moves.
    rd_q = '{32'd5, 32'hFFFF_FFFE, 32'd6, 32'd1, 32'd6};
    v = '{2'd3, 5'b0, 64'h0, 0, -1, 1, 6, 1'b0, 64'h0000_0006_0000_0001};
    do_vec(v, "rd_one_retry");

    rd_q = '{32'd7, 32'h1234, 32'd7};
    v = '{2'd3, 5'b0, 64'h0, 1, -1, 0, 7, 1'b0, 64'h0000_0007_0000_1234};
    do_vec(v, "rd_no_retry_stalled");

    // High word changes on every read: retries run out.
    rd_q = '{32'd0, 32'd10, 32'd1, 32'd11, 32'd2, 32'd12, 32'd3, 32'd13, 32'd4};
    v = '{2'd3, 5'b0, 64'h0, 0, -1, 3, 10, 1'b1, 64'h0000_0004_0000_000D};
    do_vec(v, "rd_retries_exhausted");

    rd_q = '{32'd9};
    v = '{2'd3, 5'b0, 64'h0, 0, 1, 0, 3, 1'b1, 64'h0};
    do_vec(v, "rd_bus_error");
    rd_q.delete();

    for (int i = 0; i < 9; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during the second msip write: request drops, no completion.
    stall_cfg = 0; err_beat = -1; beat_idx = 0; stall_cnt = 0; mon_q.delete();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_mask = 5'b00011; cmd_data = '0;
    bus_cycle();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    bus_cycle();
    @(negedge clk);
    check("midrst_second_access", {req.valid, req.addr}, {1'b1, BASE + 32'h4});
    rst = 1'b1;
    bus_cycle();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid_dropped", req.valid, 0);
    check("midrst_no_done", done, 0);
    check("midrst_ready", cmd_ready, 1);
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      bus_cycle();
      @(negedge clk);
      if (done || req.valid) saw_done++;
    end
    check("midrst_quiet_after", saw_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
